nrad_seq: RTL and testbench

- Iterative, parametrised non-restoring array divider (NRAD) that successor-generalises the fixed 4-bit/2-bit combinational NRAD.
- Resolves one quotient bit per clock using a single row of controlled add/subtract (CAS) logic, then runs one remainder-correction cycle.
- Start/busy/done handshake.
- Sits as a multi-cycle arithmetic unit beside the adder/divider blocks; any width is supported without growing the array.

---
 rtl/nrad_seq.sv | 87 ++++++++
 tb/tb_nrad_seq.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nrad_seq.sv
// nrad_seq: iterative non-restoring divider, one quotient bit per clock plus one correction cycle.
// Define NRAD_SIGNED_EN for two's complement operands (truncating division, remainder follows dividend).
module nrad_seq #(
  parameter int N = 8,
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] X,
  input  logic [M-1:0] Y,
  output logic         busy,
  output logic         done,
  output logic         dz,
  output logic [N-1:0] Q,
  output logic [M-1:0] R
);
  localparam int KW = $clog2(N);
  localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, CORR = 2'd2, DONE = 2'd3;
  logic [1:0] st;
  logic [N-1:0] d, qr, xm, qv;
  logic [M-1:0] dv, ym, rv;
  logic [M:0] p, ps, pn, dvx;
  logic [KW-1:0] k;
  logic zr;
`ifdef NRAD_SIGNED_EN
  logic sx, sy;
  assign xm = X[N-1] ? -X : X;
  assign ym = Y[M-1] ? -Y : Y;
  assign qv = (sx ^ sy) ? -qr : qr;
  assign rv = sx ? -p[M-1:0] : p[M-1:0];
`else
  assign xm = X;
  assign ym = Y;
  assign qv = qr;
  assign rv = p[M-1:0];
`endif
  assign dvx = {1'b0, dv};
  assign ps = {p[M-1:0], d[N-1]};
  assign pn = p[M] ? ps + dvx : ps - dvx;
  // outputs are registered one cycle behind the state; a zero divisor passes through the (no-op) correction cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      dz <= 1'b0;
      Q <= '0;
      R <= '0;
    end else begin
      busy <= (st == CALC) || (st == CORR);
      done <= (st == DONE);
      case (st)
        IDLE: if (start) begin
          d <= xm;
          dv <= ym;
          p <= '0;
          qr <= '0;
          k <= KW'(N - 1);
          zr <= (ym == '0);
          st <= (ym == '0) ? CORR : CALC;
`ifdef NRAD_SIGNED_EN
          sx <= X[N-1];
          sy <= Y[M-1];
`endif
        end
        CALC: begin
          d <= d << 1;
          p <= pn;
          qr <= {qr[N-2:0], ~pn[M]};
          k <= k - 1'b1;
          if (k == '0) st <= CORR;
        end
        CORR: begin
          if (p[M]) p <= p + dvx;
          st <= DONE;
        end
        DONE: begin
          dz <= zr;
          Q <= zr ? '1 : qv;
          R <= rv;
          st <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_nrad_seq.sv
// tb_nrad_seq: directed and randomized checks of nrad_seq against an arithmetic reference model.
module tb_nrad_seq;
  logic clk = 1'b0;
  logic rst, start, start2;
  logic [7:0] xa, qa;
  logic [3:0] ya, ra;
  logic busy, done, dz;
  logic [3:0] xb, qb;
  logic [1:0] yb, rb;
  logic busy2, done2, dz2;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nrad_seq #(.N(8), .M(4)) dut_a (.clk(clk), .rst(rst), .start(start), .X(xa), .Y(ya),
    .busy(busy), .done(done), .dz(dz), .Q(qa), .R(ra));
  nrad_seq #(.N(4), .M(2)) dut_b (.clk(clk), .rst(rst), .start(start2), .X(xb), .Y(yb),
    .busy(busy2), .done(done2), .dz(dz2), .Q(qb), .R(rb));

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic void ref_div(input int n, input int m, input int xv, input int yv,
                                  output int qe, output int re);
    int xs, ys;
    xs = xv;
    ys = yv;
`ifdef NRAD_SIGNED_EN
    if (xv >= (1 << (n - 1))) xs = xv - (1 << n);
    if (yv >= (1 << (m - 1))) ys = yv - (1 << m);
`endif
    if (ys == 0) begin
      qe = (1 << n) - 1;
      re = 0;
    end else begin
      qe = (xs / ys) & ((1 << n) - 1);
      re = (xs % ys) & ((1 << m) - 1);
    end
  endfunction

  task automatic run_a(input logic [7:0] xv, input logic [3:0] yv);
    int qe, re, lat, cnt;
    logic busy_ok;
    ref_div(8, 4, int'(xv), int'(yv), qe, re);
    lat = (yv == 0) ? 2 : 10;
    xa = xv;
    ya = yv;
    start = 1'b1;
    tick;
    start = 1'b0;
    cnt = 0;
    busy_ok = 1'b1;
    while (done !== 1'b1 && cnt < 40) begin
      if (busy !== (cnt >= 1)) busy_ok = 1'b0;
      tick;
      cnt++;
    end
    if (busy !== 1'b0) busy_ok = 1'b0;
    checks++;
    if (cnt != lat) begin
      errors++;
      $display("FAIL latency x=%0d y=%0d got %0d want %0d", xv, yv, cnt, lat);
    end
    checks++;
    if (!busy_ok) begin
      errors++;
      $display("FAIL busy_window x=%0d y=%0d got 0 want 1", xv, yv);
    end
    checks++;
    if (dz !== (yv == 0)) begin
      errors++;
      $display("FAIL dz x=%0d y=%0d got %0b want %0b", xv, yv, dz, yv == 0);
    end
    checks++;
    if (qa !== qe[7:0]) begin
      errors++;
      $display("FAIL quotient x=%0d y=%0d got %0h want %0h", xv, yv, qa, qe[7:0]);
    end
    checks++;
    if (ra !== re[3:0]) begin
      errors++;
      $display("FAIL remainder x=%0d y=%0d got %0h want %0h", xv, yv, ra, re[3:0]);
    end
  endtask

  task automatic run_b(input logic [3:0] xv, input logic [1:0] yv);
    int qe, re, lat, cnt;
    ref_div(4, 2, int'(xv), int'(yv), qe, re);
    lat = (yv == 0) ? 2 : 6;
    xb = xv;
    yb = yv;
    start2 = 1'b1;
    tick;
    start2 = 1'b0;
    cnt = 0;
    while (done2 !== 1'b1 && cnt < 40) begin
      tick;
      cnt++;
    end
    checks++;
    if (cnt != lat || qb !== qe[3:0] || rb !== re[1:0]) begin
      errors++;
      $display("FAIL sweep x=%0d y=%0d got lat=%0d q=%0h r=%0h want lat=%0d q=%0h r=%0h",
               xv, yv, cnt, qb, rb, lat, qe[3:0], re[1:0]);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    start2 = 1'b0;
    xa = '0; ya = '0; xb = '0; yb = '0;
    tick;
    tick;
    rst = 1'b0;
    checks++;
    if ({busy, done, dz, qa, ra} !== '0 || {busy2, done2, dz2, qb, rb} !== '0) begin
      errors++;
      $display("FAIL reset_state got %0h/%0h want 0/0", {busy, done, dz, qa, ra}, {busy2, done2, dz2, qb, rb});
    end
  endtask

  task automatic test_basic;
    run_a(8'd100, 4'd7);
    checks++;
    if (qa !== 8'd14 || ra !== 4'd2) begin
      errors++;
      $display("FAIL basic_100_7 got q=%0d r=%0d want q=14 r=2", qa, ra);
    end
    tick;
    checks++;
    if (done !== 1'b0 || qa !== 8'd14 || ra !== 4'd2) begin
      errors++;
      $display("FAIL done_pulse_hold got done=%0b q=%0d r=%0d want done=0 q=14 r=2", done, qa, ra);
    end
  endtask

  task automatic test_back_to_back;
    run_a(8'd255, 4'd1);
    checks++;
    if (qa !== 8'd255 || ra !== 4'd0) begin
      errors++;
      $display("FAIL b2b_255_1 got q=%0d r=%0d want q=255 r=0", qa, ra);
    end
    run_a(8'd5, 4'd9);
    checks++;
    if (qa !== 8'd0 || ra !== 4'd5) begin
      errors++;
      $display("FAIL b2b_5_9 got q=%0d r=%0d want q=0 r=5", qa, ra);
    end
    run_a(8'd0, 4'd15);
    checks++;
    if (qa !== 8'd0 || ra !== 4'd0) begin
      errors++;
      $display("FAIL b2b_0_15 got q=%0d r=%0d want q=0 r=0", qa, ra);
    end
  endtask

  task automatic test_div_zero;
    run_a(8'd37, 4'd0);
    checks++;
    if (dz !== 1'b1 || qa !== 8'hFF || ra !== 4'd0) begin
      errors++;
      $display("FAIL dz_37_0 got dz=%0b q=%0h r=%0h want dz=1 q=ff r=0", dz, qa, ra);
    end
    repeat (3) tick;
    checks++;
    if (dz !== 1'b1 || qa !== 8'hFF) begin
      errors++;
      $display("FAIL dz_hold got dz=%0b q=%0h want dz=1 q=ff", dz, qa);
    end
    run_a(8'd100, 4'd7);
  endtask

  task automatic test_ignored_start;
    int qe, re, cnt;
    ref_div(8, 4, 200, 3, qe, re);
    xa = 8'd200;
    ya = 4'd3;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (3) tick;
    xa = 8'd1;
    ya = 4'd1;
    start = 1'b1;
    tick;
    start = 1'b0;
    cnt = 4;
    while (done !== 1'b1 && cnt < 40) begin
      tick;
      cnt++;
    end
    checks++;
    if (cnt != 10 || qa !== qe[7:0] || ra !== re[3:0]) begin
      errors++;
      $display("FAIL ignored_start got lat=%0d q=%0h r=%0h want lat=10 q=%0h r=%0h", cnt, qa, ra, qe[7:0], re[3:0]);
    end
  endtask

  task automatic test_mid_reset;
    xa = 8'd200;
    ya = 4'd3;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (4) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checks++;
    if ({busy, done, dz, qa, ra} !== '0) begin
      errors++;
      $display("FAIL mid_reset got %0h want 0", {busy, done, dz, qa, ra});
    end
    run_a(8'd100, 4'd7);
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++) run_a(8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)));
  endtask

  task automatic test_sweep;
    for (int xv = 0; xv < 16; xv++)
      for (int yv = 1; yv < 4; yv++) run_b(4'(xv), 2'(yv));
  endtask

`ifdef NRAD_SIGNED_EN
  task automatic test_signed;
    run_a(8'h9C, 4'd7);
    checks++;
    if (qa !== 8'hF2 || ra !== 4'hE) begin
      errors++;
      $display("FAIL signed_m100_7 got q=%0h r=%0h want q=f2 r=e", qa, ra);
    end
    run_a(8'd100, 4'h9);
    checks++;
    if (qa !== 8'hF2 || ra !== 4'd2) begin
      errors++;
      $display("FAIL signed_100_m7 got q=%0h r=%0h want q=f2 r=2", qa, ra);
    end
    run_a(8'h80, 4'hF);
    checks++;
    if (qa !== 8'h80 || ra !== 4'd0) begin
      errors++;
      $display("FAIL signed_m128_m1 got q=%0h r=%0h want q=80 r=0", qa, ra);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_div_zero;
    test_ignored_start;
    test_mid_reset;
    test_random;
    test_sweep;
`ifdef NRAD_SIGNED_EN
    test_signed;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
